half_subtractor_st: RTL and testbench
=====================================

Name: half_subtractor_st

Overview:
- Registered, WIDTH-lane bitwise half subtractor with a valid/ready handshake.
- Each lane computes difference = a XOR b and borrow = (NOT a) AND b on its own bit; there is no borrow propagation between lanes.
- Used as a leaf arithmetic stage in datapaths needing per-bit subtract/borrow flags. With WIDTH=1 it is a pipelined 1-bit half subtractor.

Parameters:
- WIDTH, 1, number of independent 1-bit half-subtractor lanes (1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/b carry a valid operand pair this cycle.
- in_ready  output  1  block can accept an operand pair this cycle.
- a  input  WIDTH  minuend bits.
- b  input  WIDTH  subtrahend bits.
- out_valid  output  1  difference/borrow hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- difference  output  WIDTH  registered a XOR b per lane.
- borrow  output  WIDTH  registered (~a) & b per lane.
- any_borrow  output  1  registered OR-reduction of borrow.

Behaviour:
- Reset (asynchronous assert, synchronous release): out_valid=0, difference=0, borrow=0, any_borrow=0.
- Lane truth table per bit (a,b -> difference,borrow): 00->00, 01->11, 10->10, 11->00.
- in_ready = (~out_valid) | out_ready. It is combinational and depends on no input other than out_ready.
- Accept: in_valid & in_ready at a rising edge. The output register loads a, b results and out_valid=1. Latency is exactly 1 cycle.
- Drain without accept: out_valid & out_ready & ~(in_valid & in_ready) clears out_valid. Data registers keep their last value.
- Simultaneous drain and accept: the new result replaces the old one and out_valid stays 1. Full throughput is one result per cycle.
- Stall: out_valid & ~out_ready holds difference, borrow and any_borrow stable and deasserts in_ready. a and b are ignored.
- in_valid=0 with an empty register: no state change.
- Reset mid-operation: any held result is discarded and out_valid drops immediately (asynchronously).
- Outputs change only on clk edges or rst. There is no combinational path from a or b to any output.
- X on a or b while in_valid=0 must not propagate into registers.

Optional Feature:
- Macro HALFSUB_BORROW_COUNT_EN.
- When defined: extra output port borrow_count, width $clog2(WIDTH+1) (minimum 1). It holds the registered population count of borrow, loaded in the same cycle as borrow. Its reset value is 0, and it holds stable under stall.
- When undefined: the port and its logic are absent. Everything else is identical.

Decomposition:
- Package halfsub_pkg: WIDTH_MAX=64 constant and a function borrow_cnt_w(width) returning $clog2(width+1) with minimum 1.
- Sub-module half_sub_cell: purely combinational 1-bit cell, structural (one XOR, one inverter, one AND). Ports a, b, difference, borrow.
- The top module instantiates WIDTH cells via generate and owns the handshake and output registers.

Test Plan:
- Reset: rst=1 mid-stream with out_valid=1 -> out_valid=0, difference=0, borrow=0, any_borrow=0 immediately.
- WIDTH=1 truth table: apply (0,0),(0,1),(1,0),(1,1) back to back with out_ready=1 -> one cycle later in turn (d,b)=(0,0),(1,1),(1,0),(0,0); any_borrow=0,1,0,0; in_ready stays 1.
- WIDTH=8: a=8'hA5, b=8'h3C -> difference=8'h99, borrow=8'h18, any_borrow=1; with the macro, borrow_count=2.
- Stall: result pending with out_ready=0 for 3 cycles while in_valid=1, a=8'hFF -> outputs hold, in_ready=0. When out_ready=1 the pending result drains and the new input is accepted the same cycle.
- Drain-only: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 next cycle, in_ready=1.
- Random: 1000 random a/b with random in_valid/out_ready -> every accepted pair is delivered exactly once, in order, matching the truth table.

Source files
------------

// File: rtl/halfsub_pkg.sv
// Shared constants and helpers for the half_subtractor_st slice.
// Optional borrow_count port is enabled by macro HALFSUB_BORROW_COUNT_EN.
package halfsub_pkg;

    localparam int WIDTH_MAX = 64;

    // Width of a population count of `width` bits, never narrower than 1.
    function automatic int borrow_cnt_w(input int width);
        int w;
        w = (width < 1) ? 1 : $clog2(width + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/half_sub_cell.sv
// One-bit combinational half subtractor: difference = a ^ b, borrow = ~a & b.
// Zero latency, no state and no backpressure.
module half_sub_cell (
    input  logic a,
    input  logic b,
    output logic difference,
    output logic borrow
);

    logic w_not_a;

    assign w_not_a    = ~a;
    assign difference = a ^ b;
    assign borrow     = w_not_a & b;

endmodule

// File: rtl/half_subtractor_st.sv
// Registered WIDTH-lane half subtractor; 1-cycle latency, one result per cycle;
// in_ready drops only while a result is held and out_ready is low. Macro HALFSUB_BORROW_COUNT_EN adds borrow_count.
module half_subtractor_st
    import halfsub_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic [WIDTH-1:0] borrow,
    output logic             any_borrow
`ifdef HALFSUB_BORROW_COUNT_EN
    ,
    output logic [borrow_cnt_w(WIDTH)-1:0] borrow_count
`endif
);

    localparam int CNT_W = borrow_cnt_w(WIDTH);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("half_subtractor_st: WIDTH out of range");
    end

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_borrow;
    logic             w_accept;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] r_borrow;
    logic             r_any_borrow;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        half_sub_cell u_cell (
            .a          (a[g]),
            .b          (b[g]),
            .difference (w_diff[g]),
            .borrow     (w_borrow[g])
        );
    end

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // Data registers load only on accept, so idle-cycle X on a/b never lands in state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_diff       <= '0;
            r_borrow     <= '0;
            r_any_borrow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_diff       <= w_diff;
                r_borrow     <= w_borrow;
                r_any_borrow <= |w_borrow;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign difference = r_diff;
    assign borrow     = r_borrow;
    assign any_borrow = r_any_borrow;

`ifdef HALFSUB_BORROW_COUNT_EN
    logic [CNT_W-1:0] w_borrow_cnt;
    logic [CNT_W-1:0] r_borrow_cnt;

    always_comb begin
        w_borrow_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_borrow_cnt = w_borrow_cnt + CNT_W'(w_borrow[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_borrow_cnt <= '0;
        end else if (w_accept) begin
            r_borrow_cnt <= w_borrow_cnt;
        end
    end

    assign borrow_count = r_borrow_cnt;
`endif

endmodule

// File: tb/tb_half_subtractor_st.sv
// Bench for half_subtractor_st: WIDTH=1 truth table and WIDTH=8 directed/random checks.
module tb_half_subtractor_st;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, any1;
    logic [0:0] diff1, bor1;

    logic       in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, any8;
    logic [7:0] diff8, bor8;

`ifdef HALFSUB_BORROW_COUNT_EN
    logic [0:0] bc1;
    logic [3:0] bc8;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    half_subtractor_st #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .a          (a1),
        .b          (b1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .difference (diff1),
        .borrow     (bor1),
        .any_borrow (any1)
`ifdef HALFSUB_BORROW_COUNT_EN
        ,
        .borrow_count (bc1)
`endif
    );

    half_subtractor_st #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .a          (a8),
        .b          (b8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .difference (diff8),
        .borrow     (bor8),
        .any_borrow (any8)
`ifdef HALFSUB_BORROW_COUNT_EN
        ,
        .borrow_count (bc8)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] bw;
    } res_t;

    // Per bit: subtract as integers; a negative result is a borrow, a nonzero result is a difference of 1.
    function automatic res_t ref_sub(input logic [7:0] x, input logic [7:0] y);
        res_t r;
        int   s;
        for (int i = 0; i < 8; i++) begin
            s       = int'(x[i]) - int'(y[i]);
            r.d[i]  = (s != 0);
            r.bw[i] = (s < 0);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    res_t       q[$];
    res_t       r;
    logic       exp_rdy;
    logic       acc;
    logic [1:0] ab;
    logic [0:0] tt_d [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [0:0] tt_b [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid8", out_valid8, 1'b0);
        chk("rst_diff8", diff8, 8'h00);
        chk("rst_borrow8", bor8, 8'h00);
        chk("rst_any8", any8, 1'b0);
        chk("rst_in_ready8", in_ready8, 1'b1);
        chk("rst_out_valid1", out_valid1, 1'b0);
`ifdef HALFSUB_BORROW_COUNT_EN
        chk("rst_count8", bc8, 4'd0);
`endif
        tick();

        // WIDTH=1 truth table, back to back
        for (int i = 0; i < 4; i++) begin
            ab         = 2'(i);
            a1         = ab[1];
            b1         = ab[0];
            in_valid1  = 1'b1;
            out_ready1 = 1'b1;
            #1;
            chk("tt_in_ready", in_ready1, 1'b1);
            tick();
            chk("tt_out_valid", out_valid1, 1'b1);
            chk("tt_diff", diff1, tt_d[i]);
            chk("tt_borrow", bor1, tt_b[i]);
            chk("tt_any", any1, tt_b[i]);
`ifdef HALFSUB_BORROW_COUNT_EN
            chk("tt_count", bc1, tt_b[i]);
`endif
        end
        in_valid1 = 1'b0;
        tick();
        chk("tt_drained", out_valid1, 1'b0);

        // WIDTH=8 directed result, held by out_ready=0
        a8         = 8'hA5;
        b8         = 8'h3C;
        in_valid8  = 1'b1;
        out_ready8 = 1'b0;
        tick();
        chk("a5_out_valid", out_valid8, 1'b1);
        chk("a5_diff", diff8, 8'h99);
        chk("a5_borrow", bor8, 8'h18);
        chk("a5_any", any8, 1'b1);
`ifdef HALFSUB_BORROW_COUNT_EN
        chk("a5_count", bc8, 4'd2);
`endif

        // Stall for 3 cycles with a new pair offered
        a8 = 8'hFF;
        b8 = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", in_ready8, 1'b0);
            tick();
            chk("stall_out_valid", out_valid8, 1'b1);
            chk("stall_diff", diff8, 8'h99);
            chk("stall_borrow", bor8, 8'h18);
            chk("stall_any", any8, 1'b1);
`ifdef HALFSUB_BORROW_COUNT_EN
            chk("stall_count", bc8, 4'd2);
`endif
        end
        out_ready8 = 1'b1;
        #1;
        chk("release_in_ready", in_ready8, 1'b1);
        tick();
        chk("swap_out_valid", out_valid8, 1'b1);
        chk("swap_diff", diff8, 8'hF0);
        chk("swap_borrow", bor8, 8'h00);
        chk("swap_any", any8, 1'b0);

        // Drain only; data registers keep their last value
        in_valid8 = 1'b0;
        tick();
        chk("drain_out_valid", out_valid8, 1'b0);
        chk("drain_in_ready", in_ready8, 1'b1);
        chk("drain_diff_kept", diff8, 8'hF0);

        // Random traffic against a queue scoreboard
        q.delete();
        for (int n = 0; n < 1000; n++) begin
            in_valid8  = ($urandom_range(0, 3) != 0);
            out_ready8 = ($urandom_range(0, 3) != 0);
            a8         = 8'($urandom);
            b8         = 8'($urandom);
            if (!in_valid8) begin
                a8 = 'x;
                b8 = 'x;
            end
            #1;
            exp_rdy = (q.size() == 0) || out_ready8;
            chk("rand_in_ready", in_ready8, exp_rdy);
            chk("rand_out_valid", out_valid8, q.size() != 0);
            if (q.size() != 0) begin
                chk("rand_diff", diff8, q[0].d);
                chk("rand_borrow", bor8, q[0].bw);
                chk("rand_any", any8, q[0].bw != 8'h00);
`ifdef HALFSUB_BORROW_COUNT_EN
                chk("rand_count", bc8, 64'($countones(q[0].bw)));
`endif
            end
            acc = in_valid8 && exp_rdy;
            if (q.size() != 0 && out_ready8) begin
                void'(q.pop_front());
            end
            if (acc) begin
                r = ref_sub(a8, b8);
                q.push_back(r);
            end
            tick();
        end

        // Asynchronous reset while a result is held
        in_valid8  = 1'b1;
        out_ready8 = 1'b0;
        a8         = 8'h0F;
        b8         = 8'hF0;
        tick();
        chk("pre_rst_out_valid", out_valid8, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid8, 1'b0);
        chk("async_rst_diff", diff8, 8'h00);
        chk("async_rst_borrow", bor8, 8'h00);
        chk("async_rst_any", any8, 1'b0);
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_out_valid", out_valid8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
